// File: rtl/jpeg_dequant_pkg.sv
// Shared constants for the JPEG dequantizer.
//   BLK_SIZE     : coefficients per 8x8 block
//   QT_AW        : quantization table address width, {chroma, idx[5:0]}
//   LUMA_BASE    : first luma table entry
//   CHROMA_BASE  : first chroma table entry
//   DEFAULT_QT   : K.1 (luma, entries 0-63) and K.2 (chroma, entries 64-127)
//                  step tables in column order, index = col*8 + row.
package jpeg_dequant_pkg;

    localparam int BLK_SIZE = 64;
    localparam int QT_AW    = 7;
    localparam int QT_DEPTH = 128;

    localparam logic [QT_AW-1:0] LUMA_BASE   = 7'd0;
    localparam logic [QT_AW-1:0] CHROMA_BASE = 7'd64;

    localparam logic [7:0] DEFAULT_QT [0:QT_DEPTH-1] = '{
        // luma, one line per column of K.1
        8'd16, 8'd12, 8'd14, 8'd14, 8'd18, 8'd24, 8'd49, 8'd72,
        8'd11, 8'd12, 8'd13, 8'd17, 8'd22, 8'd35, 8'd64, 8'd92,
        8'd10, 8'd14, 8'd16, 8'd22, 8'd37, 8'd55, 8'd78, 8'd95,
        8'd16, 8'd19, 8'd24, 8'd29, 8'd56, 8'd64, 8'd87, 8'd98,
        8'd24, 8'd26, 8'd40, 8'd51, 8'd68, 8'd81, 8'd103, 8'd112,
        8'd40, 8'd58, 8'd57, 8'd87, 8'd109, 8'd104, 8'd121, 8'd100,
        8'd51, 8'd60, 8'd69, 8'd80, 8'd103, 8'd113, 8'd120, 8'd103,
        8'd61, 8'd55, 8'd56, 8'd62, 8'd77, 8'd92, 8'd101, 8'd99,
        // chroma, one line per column of K.2
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

endpackage

// File: rtl/rom_dqtable.sv
// 128x8 quantization step table: one write port, one registered read port,
// single clock. Powers up with the default K.1/K.2 contents; reset never
// touches it, so runtime writes survive a reset.
// Ports:
//   clk   : clock
//   we    : write strobe
//   waddr : write address {chroma, idx}
//   wdata : write data
//   raddr : read address {chroma, idx}
//   rdata : registered read data, valid the cycle after raddr
import jpeg_dequant_pkg::*;

module rom_dqtable (
    input  logic             clk,
    input  logic             we,
    input  logic [QT_AW-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [QT_AW-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem [0:QT_DEPTH-1] = DEFAULT_QT;

    // Read and write share the edge; the non-blocking read returns the
    // value stored before a same-cycle write to the same address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dequant.sv
// JPEG dequantizer: multiplies each quantized coefficient (column order)
// by the step from the luma or chroma table selected at start of block.
// Fixed 3-cycle pipeline, one coefficient per clock, no backpressure:
// a coefficient is transferred whenever en is high, and dq_en marks a
// result exactly three cycles later; there is no ready in either direction.
// Optional feature: define DEQUANT_SAT_EN to clamp the output to the
// signed OW range; otherwise the output is the low OW bits of the product.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   en, sob, chroma, d   : coefficient valid, start of block, table select
//                          (sampled on en & sob), quantized coefficient
//   qt_we, qt_addr, qt_data : table write port, qt_addr = {chroma, idx}
//   dq_en, dq_sob, dq_eob, dq : output valid, coefficient 0, coefficient 63,
//                          dequantized coefficient
//   sync_err             : pulse when sob arrives inside an incomplete block
import jpeg_dequant_pkg::*;

module dequant #(
    parameter int QW = 12,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 sob,
    input  logic                 chroma,
    input  logic [QW-1:0]        d,
    input  logic                 qt_we,
    input  logic [QT_AW-1:0]     qt_addr,
    input  logic [7:0]           qt_data,
    output logic                 dq_en,
    output logic                 dq_sob,
    output logic                 dq_eob,
    output logic [OW-1:0]        dq,
    output logic                 sync_err
);

    localparam int PW = QW + 9;

    // ---------------- stage 0: position tracking, table address ----------
    logic [5:0]       cnt;
    logic             chroma_q;
    logic [5:0]       eff_idx;
    logic             rd_tbl;
    logic [QT_AW-1:0] rd_addr;

    assign eff_idx = sob ? 6'd0 : cnt;
    assign rd_tbl  = sob ? chroma : chroma_q;
    assign rd_addr = {rd_tbl, eff_idx};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= 6'd0;
            chroma_q <= 1'b0;
        end else if (en) begin
            if (sob) begin
                cnt      <= 6'd1;
                chroma_q <= chroma;
            end else begin
                cnt <= cnt + 6'd1;   // 63 wraps to 0 naturally
            end
        end
    end

    // ---------------- stage 1: table read, delayed coefficient -----------
    logic [7:0]    step;
    logic          v1, sob1, eob1;
    logic [QW-1:0] d1;

    rom_dqtable u_table (
        .clk   (clk),
        .we    (qt_we),
        .waddr (qt_addr),
        .wdata (qt_data),
        .raddr (rd_addr),
        .rdata (step)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1       <= 1'b0;
            sob1     <= 1'b0;
            eob1     <= 1'b0;
            d1       <= '0;
            sync_err <= 1'b0;
        end else begin
            v1       <= en;
            sob1     <= en && (eff_idx == 6'd0);
            eob1     <= en && (eff_idx == 6'(BLK_SIZE - 1));
            d1       <= d;
            sync_err <= en && sob && (cnt != 6'd0);
        end
    end

    // ---------------- stage 2: exact product ------------------------------
    logic                 v2, sob2, eob2;
    logic signed [PW-1:0] prod;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2   <= 1'b0;
            sob2 <= 1'b0;
            eob2 <= 1'b0;
            prod <= '0;
        end else begin
            v2   <= v1;
            sob2 <= sob1;
            eob2 <= eob1;
            // Operands are extended to PW bits by the assignment context,
            // so the signed product is exact. Step is always non-negative.
            prod <= $signed(d1) * $signed({1'b0, step});
        end
    end

    // ---------------- stage 3: output conversion --------------------------
    logic [OW-1:0] conv;

`ifdef DEQUANT_SAT_EN
    // In range exactly when every bit above the output sign bit equals
    // the product sign bit.
    always_comb begin
        conv = prod[OW-1:0];
        if (prod[PW-1:OW-1] != {(PW-OW+1){prod[PW-1]}}) begin
            conv = prod[PW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
    end
`else
    assign conv = prod[OW-1:0];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dq_en  <= 1'b0;
            dq_sob <= 1'b0;
            dq_eob <= 1'b0;
            dq     <= '0;
        end else begin
            dq_en  <= v2;
            dq_sob <= sob2;
            dq_eob <= eob2;
            if (v2) begin
                dq <= conv;
            end
        end
    end

endmodule

// File: tb/tb_dequant.sv
module tb_dequant;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en, sob, chroma;
    logic [11:0] d;
    logic        qt_we;
    logic [6:0]  qt_addr;
    logic [7:0]  qt_data;
    logic        dq_en, dq_sob, dq_eob, sync_err;
    logic [15:0] dq;

    dequant #(.QW(12), .OW(16)) dut (
        .clk(clk), .rstn(rstn), .en(en), .sob(sob), .chroma(chroma), .d(d),
        .qt_we(qt_we), .qt_addr(qt_addr), .qt_data(qt_data),
        .dq_en(dq_en), .dq_sob(dq_sob), .dq_eob(dq_eob), .dq(dq),
        .sync_err(sync_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Steps written row-major as printed in K.1 / K.2; stored in column order.
    int luma_rm [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99};
    int chroma_rm [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99};
    int ref_qt [128];

    int  m_pos    = 0;   // position of the next coefficient within its block
    int  m_chroma = 0;
    int  cyc      = 0;

    // expected output: {due cycle[31:0], sob, eob, dq[15:0]}
    logic [49:0] exp_q[$];
    int          sync_q[$];

    // observed outputs, for directed checks against spec constants
    logic [15:0] got_dq[$];
    bit          got_sob[$];
    bit          got_eob[$];
    int          sync_seen = 0;

    function automatic logic [15:0] model_dq(input int coef, input int step);
        int p;
        p = coef * step;
`ifdef DEQUANT_SAT_EN
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
`endif
        return 16'(p);
    endfunction

    // Sampled on the falling edge: check what the last rising edge produced,
    // then model the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            check("rst_dq_en", 32'(dq_en), 32'd0);
            check("rst_dq_sob", 32'(dq_sob), 32'd0);
            check("rst_dq_eob", 32'(dq_eob), 32'd0);
            check("rst_dq", 32'(dq), 32'd0);
            check("rst_sync_err", 32'(sync_err), 32'd0);
            exp_q.delete();
            sync_q.delete();
            m_pos    = 0;
            m_chroma = 0;
        end else begin
            logic [49:0] e;
            bit          exp_sync;
            int          idx, tbl, coef;
            if (exp_q.size() > 0 && exp_q[0][49:18] == 32'(cyc)) begin
                e = exp_q.pop_front();
                check("dq_en", 32'(dq_en), 32'd1);
                check("dq_sob", 32'(dq_sob), 32'(e[17]));
                check("dq_eob", 32'(dq_eob), 32'(e[16]));
                check("dq", 32'(dq), 32'(e[15:0]));
            end else begin
                check("dq_en_idle", 32'(dq_en), 32'd0);
            end
            if (dq_en) begin
                got_dq.push_back(dq);
                got_sob.push_back(dq_sob);
                got_eob.push_back(dq_eob);
            end
            exp_sync = (sync_q.size() > 0 && sync_q[0] == cyc);
            if (exp_sync) void'(sync_q.pop_front());
            check("sync_err", 32'(sync_err), 32'(exp_sync));
            if (sync_err) sync_seen++;

            if (en) begin
                idx  = sob ? 0 : m_pos;
                tbl  = sob ? int'(chroma) : m_chroma;
                coef = int'($signed(d));
                if (sob && m_pos != 0) sync_q.push_back(cyc + 1);
                e = {32'(cyc + 3), (idx == 0), (idx == 63),
                     model_dq(coef, ref_qt[tbl * 64 + idx])};
                exp_q.push_back(e);
                if (sob) m_chroma = int'(chroma);
                m_pos = (idx + 1) % 64;
            end
            if (qt_we) ref_qt[qt_addr] = int'(qt_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic c, input int dv);
        en = 1'b1; sob = s; chroma = c; d = 12'(dv);
        tick();
    endtask

    task automatic idle(input int n);
        en = 1'b0; sob = 1'b0; qt_we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic qt_write(input int a, input int v);
        en = 1'b0; qt_we = 1'b1; qt_addr = 7'(a); qt_data = 8'(v);
        tick();
        qt_we = 1'b0;
    endtask

    task automatic clear_capture();
        got_dq.delete();
        got_sob.delete();
        got_eob.delete();
        sync_seen = 0;
    endtask

    // ---------------- stimulus ----------------
    int luma_first [9] = '{16, 12, 14, 14, 18, 24, 49, 72, 11};

    initial begin
        int pos;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                ref_qt[c * 8 + r]      = luma_rm[r * 8 + c];
                ref_qt[64 + c * 8 + r] = chroma_rm[r * 8 + c];
            end
        rstn = 1'b0; en = 1'b0; sob = 1'b0; chroma = 1'b0; d = '0;
        qt_we = 1'b0; qt_addr = '0; qt_data = '0;
        repeat (3) tick();
        rstn = 1'b1;
        idle(2);

        // luma block, d = 1
        clear_capture();
        send(1'b1, 1'b0, 1);
        for (int i = 1; i < 64; i++) send(1'b0, 1'b0, 1);
        idle(5);
        check("luma_count", 32'(got_dq.size()), 32'd64);
        for (int i = 0; i < 9; i++) check("luma_step", 32'(got_dq[i]), 32'(luma_first[i]));
        check("luma_sob_first", 32'(got_sob[0]), 32'd1);
        check("luma_eob_62", 32'(got_eob[62]), 32'd0);
        check("luma_eob_last", 32'(got_eob[63]), 32'd1);

        // sign handling
        clear_capture();
        send(1'b1, 1'b0, -3);
        idle(4);
        check("neg_luma", 32'(got_dq[0]), 32'(16'hFFD0));   // -48
        clear_capture();
        send(1'b1, 1'b1, 0);
        send(1'b0, 1'b1, 0);
        send(1'b0, 1'b1, 0);
        send(1'b0, 1'b1, -2);
        idle(4);
        check("neg_chroma", 32'(got_dq[3]), 32'(16'hFFA2)); // -94

        // saturation / wrap at chroma index 4 and 5 (step 99)
        clear_capture();
        send(1'b1, 1'b1, 0);
        for (int i = 1; i < 4; i++) send(1'b0, 1'b1, 0);
        send(1'b0, 1'b1, 2047);
        send(1'b0, 1'b1, -2048);
        idle(4);
`ifdef DEQUANT_SAT_EN
        check("sat_pos", 32'(got_dq[4]), 32'd32767);
        check("sat_neg", 32'(got_dq[5]), 32'(16'h8000));
`else
        check("wrap_pos", 32'(got_dq[4]), 32'd6045);
        check("wrap_neg", 32'(got_dq[5]), 32'(16'hE800)); // -6144
`endif

        // table write: same-cycle read returns old step, next block new step
        clear_capture();
        qt_we = 1'b1; qt_addr = 7'd0; qt_data = 8'd5;
        send(1'b1, 1'b0, 1);
        qt_we = 1'b0;
        send(1'b1, 1'b0, 7);
        idle(4);
        check("qt_same_cycle", 32'(got_dq[0]), 32'd16);
        check("qt_written", 32'(got_dq[1]), 32'd35);

        // reset with three coefficients in flight
        send(1'b1, 1'b0, 5);
        send(1'b0, 1'b0, 5);
        send(1'b0, 1'b0, 5);
        en = 1'b0; sob = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_async_dq_en", 32'(dq_en), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        clear_capture();
        idle(6);
        check("rst_no_output", 32'(got_dq.size()), 32'd0);
        send(1'b1, 1'b0, 7);
        idle(4);
        check("qt_kept_after_rst", 32'(got_dq[0]), 32'd35);
        for (int i = 1; i < 64; i++) send(1'b0, 1'b0, 0);
        qt_write(0, 16);
        idle(4);

        // resync: sob at effective index 10
        clear_capture();
        send(1'b1, 1'b0, 1);
        for (int i = 1; i < 10; i++) send(1'b0, 1'b0, 1);
        send(1'b1, 1'b0, 1);
        idle(5);
        check("resync_pulses", 32'(sync_seen), 32'd1);
        check("resync_count", 32'(got_dq.size()), 32'd11);
        check("resync_sob", 32'(got_sob[10]), 32'd1);
        check("resync_dq", 32'(got_dq[10]), 32'd16);

        // random traffic against the model
        pos = 1;
        for (int i = 0; i < 2000; i++) begin
            en      = ($urandom_range(7) != 0);
            sob     = en && ((pos == 0) || ($urandom_range(63) == 0));
            chroma  = 1'($urandom_range(1));
            d       = 12'($urandom_range(4095));
            qt_we   = ($urandom_range(24) == 0);
            qt_addr = 7'($urandom_range(127));
            qt_data = 8'($urandom_range(255));
            if (en) pos = sob ? 1 : (pos + 1) % 64;
            tick();
        end
        idle(6);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dequant.md
# dequant

Dequantizer for the JPEG decode path: multiplies each quantized coefficient by its quantization step to recover the DCT coefficient for the 2-D IDCT. It is the inverse of the encoder quantizer and uses the same column-order table layout, luma at entries 0–63 and chroma at 64–127. A coefficient counter tracks position inside the 8x8 block and selects the table entry. The table is runtime-writable.

## Interface
- `QW`, 12: quantized coefficient input width (signed).
- `OW`, 16: dequantized output width (signed).
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `en` in 1: input coefficient valid.
- `sob` in 1: start of block; qualified by `en`; marks coefficient 0.
- `chroma` in 1: table select; sampled only on `en & sob`.
- `d` in QW: quantized coefficient, column order.
- `qt_we` in 1: table write strobe.
- `qt_addr` in 7: table write address, `{chroma, idx[5:0]}`.
- `qt_data` in 8: table write data.
- `dq_en` out 1: output valid.
- `dq_sob` out 1: output is coefficient 0.
- `dq_eob` out 1: output is coefficient 63.
- `dq` out OW: dequantized coefficient.
- `sync_err` out 1: one-cycle pulse when `sob` arrives while a block is incomplete.

## Operation
- The coefficient counter `cnt[5:0]` starts at 0 after reset. It advances on every `en`.
- On `en & sob`:
  - effective index = 0;
  - `cnt` loads 1;
  - `chroma` is latched into `chroma_q`.
- On `en` without `sob`:
  - effective index = `cnt`;
  - `cnt` increments and wraps from 63 to 0.
- Table read address = `{sob ? chroma : chroma_q, effective index}`.
- Product = `$signed(d) * $signed({1'b0, step})`, width QW+9 bits, computed exactly.
- Output conversion:
  - With `DEQUANT_SAT_EN`, the product is clamped to [−2^(OW−1), 2^(OW−1)−1].
  - Without it, the output is the low OW bits of the product.
- A stored step of 0 yields `dq` = 0. No substitution is made.
- `dq_sob` and `dq_eob` are computed from the effective index: 0 and 63 respectively.
- `sync_err` pulses when `en & sob` arrives while `cnt` ≠ 0. Processing continues and the counter resynchronises. `en` without a prior `sob` after reset is accepted with `chroma_q` = 0 (luma).
- Table writes:
  - Take effect on the clock edge of `qt_we`.
  - A same-cycle read of the same address returns the old value.
  - Reset value is K.1 (luma) / K.2 (chroma) in column order, loaded by initial contents. Reset does not reload the table.

## Timing
- Fixed 3-cycle pipeline with no stalls: `en` at cycle t produces `dq_en` at t+3.
  - t+1: registered table read; `d` delayed 1 cycle.
  - t+2: registered product.
  - t+3: registered saturate/truncate result.
- Back-to-back `en` on every cycle is supported. Full throughput is one coefficient per clock.
- `dq_sob`, `dq_eob` and `dq` align with `dq_en`. `sync_err` is registered at t+1.
- Reset values: `dq_en`, `dq_sob`, `dq_eob`, `sync_err` = 0; `dq` = 0; `cnt` = 0; `chroma_q` = 0. Reset flushes all in-flight pipeline valids.
- Reset mid-block discards partial data. No output appears until 3 cycles after the next `en`.

## Configuration
- `DEQUANT_SAT_EN` defined: the output stage clamps to the signed OW range.
- `DEQUANT_SAT_EN` undefined: the output stage truncates to the low OW bits (two's-complement wrap). This saves the comparator logic.

## Structure
- Shared package `jpeg_dequant_pkg` holds:
  - `BLK_SIZE` = 64;
  - table address width 7;
  - `LUMA_BASE` = 0, `CHROMA_BASE` = 64;
  - the default K.1/K.2 column-order step constants used for initial table contents.
- Sub-module `rom_dqtable`: 128x8 simple dual-port RAM with one write port and one registered read port, same clock.
- The counter, pipeline and saturation logic live in `dequant`.

## Test plan
- Luma block: `sob` + 64 `en` with `d` = 1, `chroma` = 0 → `dq` sequence 16,12,14,14,18,24,49,72,11,… matches K.1 column order. `dq_sob` on the first output, `dq_eob` on the 64th. First `dq_en` 3 cycles after first `en`.
- Sign: luma index 0 with `d` = −3 → `dq` = −48. Chroma index 3 with `d` = −2 → `dq` = −94.
- Saturation: chroma index 4 (step 99) with `d` = 2047:
  - with `DEQUANT_SAT_EN` → `dq` = 32767;
  - without → `dq` = 6045;
  - `d` = −2048 with the macro → −32768.
- Resync: `sob` at effective index 10 → `sync_err` pulses once; that output has `dq_sob` = 1 and uses step 16 (luma index 0).
- Table write: `qt_we`, `qt_addr` = 0, `qt_data` = 5, then a luma block with `d` = 7 → first `dq` = 35. A same-cycle read of address 0 with `d` = 1 returns 16.
- Reset: assert `rstn` low with 3 coefficients in flight → all outputs 0 immediately. No `dq_en` after release until new input arrives. The table keeps any written values.
